// File: rtl/jtframe_z80_romslot.sv
// ---------------------------------------------------------------------------
// jtframe_z80_romslot: one-word ROM cache serving Z80 byte reads, refilled
// from SDRAM over a req/ack/dok handshake. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jtframe_z80_romslot #(
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rom_cs,
   input  logic [AW-1:0] rom_addr,
   output logic [7:0]    rom_data,
   output logic          rom_ok,
   input  logic          flush,
   output logic          sdram_req,
   output logic [AW-2:0] sdram_addr,
   input  logic          sdram_ack,
   input  logic          sdram_dok,
   input  logic [15:0]   sdram_data,
   output logic [15:0]   miss_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t        r_state;
   logic [15:0]   r_word;
   logic [AW-2:0] r_tag;
   logic          r_valid;
   logic          r_drop;
   logic          r_req;
   logic [AW-2:0] r_addr;
   logic [15:0]   r_cnt;
   logic          w_hit;

   assign w_hit      = r_valid && (r_tag == rom_addr[AW-1:1]);
   assign rom_ok     = rom_cs && w_hit;
   assign rom_data   = rom_addr[0] ? r_word[15:8] : r_word[7:0];
   assign sdram_req  = r_req;
   assign sdram_addr = r_addr;
   assign miss_cnt   = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_word  <= 16'h0000;
         r_tag   <= '0;
         r_valid <= 1'b0;
         r_drop  <= 1'b0;
         r_req   <= 1'b0;
         r_addr  <= '0;
         r_cnt   <= 16'h0000;
      end else begin
         if (flush) r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (rom_cs && !w_hit && !flush) begin
                  r_state <= S_REQ;
                  r_req   <= 1'b1;
                  r_addr  <= rom_addr[AW-1:1];
                  r_drop  <= 1'b0;
                  if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
               end
            end
            S_REQ: begin
               if (flush) r_drop <= 1'b1;
               if (sdram_ack) begin
                  r_req <= 1'b0;
                  // ack and dok together complete the fetch without visiting WAIT
                  if (sdram_dok) begin
                     r_word  <= sdram_data;
                     r_tag   <= r_addr;
                     r_valid <= !(r_drop || flush);
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (flush) r_drop <= 1'b1;
               if (sdram_dok) begin
                  r_word  <= sdram_data;
                  r_tag   <= r_addr;
                  r_valid <= !(r_drop || flush);
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_z80_romslot.sv
// ---------------------------------------------------------------------------
// tb_jtframe_z80_romslot: directed scenarios plus randomized traffic checked
// against a transaction-level cache model. Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jtframe_z80_romslot;

   logic        clk;
   logic        rst_n;
   logic        rom_cs;
   logic [14:0] rom_addr;
   logic [7:0]  rom_data;
   logic        rom_ok;
   logic        flush;
   logic        sdram_req;
   logic [13:0] sdram_addr;
   logic        sdram_ack;
   logic        sdram_dok;
   logic [15:0] sdram_data;
   logic [15:0] miss_cnt;

   int n_cmp;
   int n_bad;

   // Model: cache contents plus the single outstanding fetch
   logic        m_valid;
   logic [13:0] m_tag;
   logic [15:0] m_word;
   logic        m_busy;
   logic        m_acked;
   logic        m_drop;
   logic [13:0] m_addr;
   int          m_cnt;

   jtframe_z80_romslot #(.AW(15)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rom_cs     (rom_cs),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .rom_ok     (rom_ok),
      .flush      (flush),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .sdram_dok  (sdram_dok),
      .sdram_data (sdram_data),
      .miss_cnt   (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_valid = 1'b0; m_tag = '0; m_word = '0; m_busy = 1'b0;
      m_acked = 1'b0; m_drop = 1'b0; m_addr = '0; m_cnt = 0;
   endtask

   // Advance one clock: decide the model's next state from the inputs seen at
   // the edge, then clear the single-cycle pulses.
   task automatic tick();
      logic hit, done;
      logic n_valid, n_busy, n_acked, n_drop;
      logic [13:0] n_tag, n_addr;
      logic [15:0] n_word;
      int n_cnt;
      hit = m_valid && (m_tag == rom_addr[14:1]);
      n_valid = flush ? 1'b0 : m_valid;
      n_tag = m_tag; n_word = m_word; n_busy = m_busy; n_acked = m_acked;
      n_drop = m_drop; n_addr = m_addr; n_cnt = m_cnt;
      if (!m_busy) begin
         if (rom_cs && !hit && !flush) begin
            n_busy = 1'b1; n_acked = 1'b0; n_drop = 1'b0;
            n_addr = rom_addr[14:1];
            n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
         end
      end else begin
         if (flush) n_drop = 1'b1;
         done = sdram_dok && (m_acked || sdram_ack);
         if (done) begin
            n_word = sdram_data; n_tag = m_addr;
            n_valid = !(m_drop || flush);
            n_busy = 1'b0; n_acked = 1'b0;
         end else if (sdram_ack) begin
            n_acked = 1'b1;
         end
      end
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         m_valid = n_valid; m_tag = n_tag; m_word = n_word; m_busy = n_busy;
         m_acked = n_acked; m_drop = n_drop; m_addr = n_addr; m_cnt = n_cnt;
      end
      #1;
      sdram_ack = 1'b0; sdram_dok = 1'b0; flush = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; rom_cs = 1'b0; rom_addr = '0; flush = 1'b0;
      sdram_ack = 1'b0; sdram_dok = 1'b0; sdram_data = '0;
      model_reset();
      tick(); tick();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (rom_ok !== 1'b0) begin n_bad++; $display("FAIL reset_rom_ok: got %b want 0", rom_ok); end
      n_cmp++; if (rom_data !== 8'h00) begin n_bad++; $display("FAIL reset_rom_data: got %h want 00", rom_data); end
      n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", sdram_req); end
      n_cmp++; if (sdram_addr !== 14'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0000", sdram_addr); end
      n_cmp++; if (miss_cnt !== 16'h0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", miss_cnt); end
   endtask

   task automatic test_cold_miss_and_hit();
      do_reset();
      rom_cs = 1'b1; rom_addr = 15'h0123; #1;
      n_cmp++; if (rom_ok !== 1'b0) begin n_bad++; $display("FAIL cold_ok_before: got %b want 0", rom_ok); end
      tick();
      n_cmp++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0091) begin n_bad++; $display("FAIL cold_req: got req=%b addr=%h want req=1 addr=0091", sdram_req, sdram_addr); end
      n_cmp++; if (miss_cnt !== 16'd1) begin n_bad++; $display("FAIL cold_cnt: got %0d want 1", miss_cnt); end
      sdram_ack = 1'b1; tick();
      n_cmp++; if (sdram_req !== 1'b0) begin n_bad++; $display("FAIL cold_req_drop: got %b want 0", sdram_req); end
      tick(); tick(); tick();
      n_cmp++; if (rom_ok !== 1'b0) begin n_bad++; $display("FAIL cold_ok_wait: got %b want 0", rom_ok); end
      sdram_dok = 1'b1; sdram_data = 16'hBEEF; tick();
      n_cmp++; if (rom_ok !== 1'b1 || rom_data !== 8'hBE) begin n_bad++; $display("FAIL cold_fill: got ok=%b data=%h want ok=1 data=BE", rom_ok, rom_data); end
      rom_addr = 15'h0122; #1;
      n_cmp++; if (rom_ok !== 1'b1 || rom_data !== 8'hEF) begin n_bad++; $display("FAIL hit_same_word: got ok=%b data=%h want ok=1 data=EF", rom_ok, rom_data); end
      tick();
      n_cmp++; if (sdram_req !== 1'b0 || miss_cnt !== 16'd1) begin n_bad++; $display("FAIL hit_no_req: got req=%b cnt=%0d want req=0 cnt=1", sdram_req, miss_cnt); end
   endtask

   task automatic test_addr_change();
      do_reset();
      rom_cs = 1'b1; rom_addr = 15'h0010; tick();
      sdram_ack = 1'b1; tick();
      rom_addr = 15'h0200;
      sdram_dok = 1'b1; sdram_data = 16'h1234; tick();
      n_cmp++; if (rom_ok !== 1'b0 || sdram_req !== 1'b0) begin n_bad++; $display("FAIL chg_after_fill: got ok=%b req=%b want ok=0 req=0", rom_ok, sdram_req); end
      rom_addr = 15'h0010; #1;
      n_cmp++; if (rom_ok !== 1'b1 || rom_data !== 8'h34) begin n_bad++; $display("FAIL chg_old_cached: got ok=%b data=%h want ok=1 data=34", rom_ok, rom_data); end
      rom_addr = 15'h0200; #1;
      tick();
      n_cmp++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0100 || miss_cnt !== 16'd2) begin n_bad++; $display("FAIL chg_second_req: got req=%b addr=%h cnt=%0d want req=1 addr=0100 cnt=2", sdram_req, sdram_addr, miss_cnt); end
      sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h7788; tick();
      rom_cs = 1'b0;
   endtask

   task automatic test_flush_wait();
      do_reset();
      rom_cs = 1'b1; rom_addr = 15'h0040; tick();
      sdram_ack = 1'b1; tick();
      flush = 1'b1; tick();
      sdram_dok = 1'b1; sdram_data = 16'hABCD; tick();
      n_cmp++; if (rom_ok !== 1'b0) begin n_bad++; $display("FAIL flush_wait_ok: got %b want 0", rom_ok); end
      tick();
      n_cmp++; if (sdram_req !== 1'b1 || sdram_addr !== 14'h0020 || miss_cnt !== 16'd2) begin n_bad++; $display("FAIL flush_refetch: got req=%b addr=%h cnt=%0d want req=1 addr=0020 cnt=2", sdram_req, sdram_addr, miss_cnt); end
      sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h4321; tick();
      n_cmp++; if (rom_ok !== 1'b1 || rom_data !== 8'h21) begin n_bad++; $display("FAIL flush_refill: got ok=%b data=%h want ok=1 data=21", rom_ok, rom_data); end
      rom_cs = 1'b0;
   endtask

   task automatic test_flush_dok_and_ack_dok();
      do_reset();
      rom_cs = 1'b1; rom_addr = 15'h0050; tick();
      sdram_ack = 1'b1; tick();
      rom_cs = 1'b0;
      flush = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h9966; tick();
      rom_cs = 1'b1; #1;
      n_cmp++; if (rom_ok !== 1'b0 || rom_data !== 8'h66) begin n_bad++; $display("FAIL flush_dok: got ok=%b data=%h want ok=0 data=66", rom_ok, rom_data); end
      rom_addr = 15'h0061; tick();
      sdram_ack = 1'b1; sdram_dok = 1'b1; sdram_data = 16'h5AA5; tick();
      n_cmp++; if (rom_ok !== 1'b1 || rom_data !== 8'h5A || sdram_req !== 1'b0) begin n_bad++; $display("FAIL ack_dok: got ok=%b data=%h req=%b want ok=1 data=5A req=0", rom_ok, rom_data, sdram_req); end
      rom_cs = 1'b0;
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      rom_cs = 1'b1; rom_addr = 15'h0070; tick();
      n_cmp++; if (sdram_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: got %b want 1", sdram_req); end
      #2; rst_n = 1'b0; model_reset(); #1;
      n_cmp++; if (sdram_req !== 1'b0 || miss_cnt !== 16'd0) begin n_bad++; $display("FAIL rstmid_async: got req=%b cnt=%0d want req=0 cnt=0", sdram_req, miss_cnt); end
      rom_cs = 1'b0; tick();
      rst_n = 1'b1;
      sdram_dok = 1'b1; sdram_data = 16'hDEAD; tick();
      rom_cs = 1'b1; #1;
      n_cmp++; if (rom_ok !== 1'b0 || rom_data !== 8'h00 || sdram_req !== 1'b0) begin n_bad++; $display("FAIL rstmid_stray_dok: got ok=%b data=%h req=%b want ok=0 data=00 req=0", rom_ok, rom_data, sdram_req); end
      rom_cs = 1'b0;
   endtask

   task automatic test_random();
      logic        e_ok;
      logic [7:0]  e_data;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         rom_cs   = ($urandom % 4) != 0;
         rom_addr = 15'($urandom_range(0, 15));
         flush    = ($urandom % 20) == 0;
         sdram_data = 16'($urandom);
         if (m_busy && !m_acked) begin
            sdram_ack = ($urandom % 2) == 0;
            sdram_dok = ($urandom % 4) == 0;
         end else if (m_busy) begin
            sdram_dok = ($urandom % 3) == 0;
         end else begin
            sdram_ack = ($urandom % 16) == 0;
            sdram_dok = ($urandom % 16) == 0;
         end
         #1;
         e_ok   = rom_cs && m_valid && (m_tag == rom_addr[14:1]);
         e_data = 8'((m_word >> (rom_addr[0] ? 8 : 0)) & 16'h00FF);
         n_cmp++; if (rom_ok !== e_ok) begin n_bad++; $display("FAIL rnd_ok[%0d]: got %b want %b", i, rom_ok, e_ok); end
         n_cmp++; if (rom_data !== e_data) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", i, rom_data, e_data); end
         n_cmp++; if (sdram_req !== (m_busy && !m_acked)) begin n_bad++; $display("FAIL rnd_req[%0d]: got %b want %b", i, sdram_req, m_busy && !m_acked); end
         n_cmp++; if (sdram_addr !== m_addr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, sdram_addr, m_addr); end
         n_cmp++; if (miss_cnt !== 16'(m_cnt)) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", i, miss_cnt, m_cnt); end
         tick();
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_cold_miss_and_hit();
      test_addr_change();
      test_flush_wait();
      test_flush_dok_and_ack_dok();
      test_reset_mid_fetch();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
